porta_logica_acc: RTL and testbench

Parametrised, registered successor to the two-input structural OR gate. It reduces a stream of WIDTH-bit operands, grouped into frames, with a selectable bitwise operation (OR, AND, XOR, XNOR) and optional output inversion. Operands enter and the result leaves through valid/ready handshakes. It sits between an operand source and a result consumer in the gate-level exercise datapath.

---
 rtl/porta_logica_acc.sv | 134 +++++++++++++
 tb/tb_porta_logica_acc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/porta_logica_acc.sv
// rtl/porta_logica_acc.sv - framed bitwise reduction (OR/AND/XOR/XNOR) with valid/ready handshakes
module porta_logica_acc #(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 16,
    parameter int CW      = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic             inv,
    input  logic [WIDTH-1:0] a,
    input  logic             in_valid,
    input  logic             last,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_acc;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic               r_inv;
    logic [WIDTH-1:0]   r_y;
    logic [CW-1:0]      r_count;
    logic               r_ovf;

    logic               w_accept;
    logic               w_deliver;
    logic [WIDTH-1:0]   w_acc_next;
    logic [CW-1:0]      w_cnt_next;
    logic               w_close;
    logic               w_inv_eff;
    logic [WIDTH-1:0]   w_y_next;

    // in_ready is a function of state and reset only, so no input-to-output path exists
    assign in_ready  = rst_n && (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign y         = r_y;
    assign count     = r_count;
    assign ovf       = r_ovf;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = out_valid && out_ready;

    // Next-state and next accumulator; the first beat seeds acc and uses the live op/inv
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_close      = 1'b0;
        w_inv_eff    = r_inv;
        w_y_next     = r_y;

        if (r_state == IDLE) begin
            w_acc_next = a;
            w_cnt_next = CW'(1);
            w_inv_eff  = inv;
        end else begin
            case (r_op)
                OP_OR:   w_acc_next = r_acc | a;
                OP_AND:  w_acc_next = r_acc & a;
                OP_XOR:  w_acc_next = r_acc ^ a;
                default: w_acc_next = ~(r_acc ^ a);
            endcase
            w_cnt_next = r_cnt + CW'(1);
        end

        w_close  = last || (w_cnt_next == CW'(MAX_OPS));
        w_y_next = w_inv_eff ? ~w_acc_next : w_acc_next;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_close ? HOLD : ACC;
                end
            end
            ACC: begin
                if (w_accept && w_close) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (w_deliver) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, accumulator and result registers; reset discards any open frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= OP_OR;
            r_inv   <= 1'b0;
            r_y     <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                if (r_state == IDLE) begin
                    r_op  <= op;
                    r_inv <= inv;
                end
                if (w_close) begin
                    r_y     <= w_y_next;
                    r_count <= w_cnt_next;
                    r_ovf   <= !last;
                end
            end
        end
    end

endmodule

// File: tb/tb_porta_logica_acc.sv
// tb/tb_porta_logica_acc.sv - directed self-checking bench for porta_logica_acc
module tb_porta_logica_acc;

    localparam int WIDTH   = 8;
    localparam int MAX_OPS = 4;
    localparam int CW      = $clog2(MAX_OPS + 1);

    logic             clk;
    logic             rst_n;
    logic [1:0]       op;
    logic             inv;
    logic [WIDTH-1:0] a;
    logic             in_valid;
    logic             last;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    int checks;
    int errors;

    porta_logica_acc #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .inv       (inv),
        .a         (a),
        .in_valid  (in_valid),
        .last      (last),
        .in_ready  (in_ready),
        .y         (y),
        .count     (count),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] av, input logic lst, input logic [1:0] opv, input logic iv);
        a        = av;
        last     = lst;
        op       = opv;
        inv      = iv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h want 00", y); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %0b want 0", in_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high: got %0b want 1", in_ready); end
    endtask

    task automatic test_or();
        send(8'h01, 1'b0, 2'b00, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL or_early_valid: got %0b want 0", out_valid); end
        send(8'h02, 1'b0, 2'b00, 1'b0);
        send(8'h80, 1'b1, 2'b00, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL or_valid: got %0b want 1", out_valid); end
        checks++; if (y !== 8'h83) begin errors++; $display("FAIL or_y: got %h want 83", y); end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL or_count: got %0d want 3", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL or_ovf: got %0b want 0", ovf); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL or_hold_ready: got %0b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL or_valid_fall: got %0b want 0", out_valid); end
        checks++; if (y !== 8'h83) begin errors++; $display("FAIL or_y_kept: got %h want 83", y); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL or_ready_back: got %0b want 1", in_ready); end
    endtask

    task automatic test_and_inv();
        send(8'hF0, 1'b0, 2'b01, 1'b1);
        send(8'h3C, 1'b1, 2'b00, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_valid: got %0b want 1", out_valid); end
        checks++; if (y !== 8'hCF) begin errors++; $display("FAIL and_inv_y: got %h want cf", y); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL and_count: got %0d want 2", count); end
        tick();
    endtask

    task automatic test_xor_xnor();
        send(8'h5A, 1'b1, 2'b10, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL xor1_valid: got %0b want 1", out_valid); end
        checks++; if (y !== 8'h5A) begin errors++; $display("FAIL xor1_y: got %h want 5a", y); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL xor1_count: got %0d want 1", count); end
        tick();
        send(8'h0F, 1'b0, 2'b11, 1'b0);
        send(8'hFF, 1'b1, 2'b11, 1'b0);
        checks++; if (y !== 8'h0F) begin errors++; $display("FAIL xnor_y: got %h want 0f", y); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL xnor_count: got %0d want 2", count); end
        tick();
        send(8'h0F, 1'b0, 2'b10, 1'b0);
        send(8'hFF, 1'b1, 2'b10, 1'b0);
        checks++; if (y !== 8'hF0) begin errors++; $display("FAIL xor2_y: got %h want f0", y); end
        tick();
    endtask

    task automatic test_overflow();
        send(8'h01, 1'b0, 2'b00, 1'b0);
        send(8'h02, 1'b0, 2'b00, 1'b0);
        send(8'h04, 1'b0, 2'b00, 1'b0);
        send(8'h08, 1'b0, 2'b00, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %0b want 1", out_valid); end
        checks++; if (y !== 8'h0F) begin errors++; $display("FAIL ovf_y: got %h want 0f", y); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", count); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", ovf); end
        // fifth beat presented during HOLD must wait for the next cycle
        a = 8'h10; last = 1'b1; in_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid_fall: got %0b want 0", out_valid); end
        tick();
        in_valid = 1'b0; last = 1'b0;
        checks++; if (y !== 8'h10) begin errors++; $display("FAIL ovf_next_y: got %h want 10", y); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL ovf_next_count: got %0d want 1", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_next_flag: got %0b want 0", ovf); end
        tick();
        // last on beat MAX_OPS is a normal close
        send(8'h01, 1'b0, 2'b00, 1'b0);
        send(8'h02, 1'b0, 2'b00, 1'b0);
        send(8'h04, 1'b0, 2'b00, 1'b0);
        send(8'h40, 1'b1, 2'b00, 1'b0);
        checks++; if (y !== 8'h47) begin errors++; $display("FAIL max_last_y: got %h want 47", y); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL max_last_count: got %0d want 4", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL max_last_ovf: got %0b want 0", ovf); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'h11, 1'b0, 2'b00, 1'b0);
        send(8'h22, 1'b1, 2'b00, 1'b0);
        a = 8'hFF; last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid); end
            checks++; if (y !== 8'h33) begin errors++; $display("FAIL bp_y[%0d]: got %h want 33", i, y); end
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL bp_count[%0d]: got %0d want 2", i, count); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        last      = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_before_deliver: got %0b want 1", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_delivered: got %0b want 0", out_valid); end
        checks++; if (y !== 8'h33) begin errors++; $display("FAIL bp_y_after: got %h want 33", y); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %0b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_frame();
        send(8'hAA, 1'b0, 2'b00, 1'b0);
        send(8'h55, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b0;
        tick();
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL mid_rst_y: got %h want 00", y); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %0b want 0", in_ready); end
        rst_n = 1'b1;
        send(8'h01, 1'b1, 2'b00, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_next_valid: got %0b want 1", out_valid); end
        checks++; if (y !== 8'h01) begin errors++; $display("FAIL mid_rst_next_y: got %h want 01", y); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL mid_rst_next_count: got %0d want 1", count); end
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        op        = 2'b00;
        inv       = 1'b0;
        a         = '0;
        in_valid  = 1'b0;
        last      = 1'b0;
        out_ready = 1'b1;
        #1;
        test_reset();
        test_or();
        test_and_inv();
        test_xor_xnor();
        test_overflow();
        test_backpressure();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
